// File: rtl/spi_byte_tx_if.sv
// Byte-stream handshake and SPI pin bundle for spi_byte_tx.
// master: the transmitter (accepts bytes, drives pins); slave: byte source / link monitor.
interface spi_byte_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       busy;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs;

  modport master (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready,
    output busy,
    output spi_sclk,
    output spi_mosi,
    output spi_cs
  );

  modport slave (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready,
    input  busy,
    input  spi_sclk,
    input  spi_mosi,
    input  spi_cs
  );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI master transmitter: serialises bytes LSB-first on sclk/mosi/cs (active-low),
// optionally chaining several bytes under one cs assertion.
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  spi_byte_tx_if.master bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] DivMax = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_no_q, bit_no_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;
  logic            mosi_q, mosi_d;

  logic            phase_end;
  logic            tx_ready;
  logic            load;
  logic            go_hold;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_no_q  <= '0;
      div_cnt_q <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_no_q  <= bit_no_d;
      div_cnt_q <= div_cnt_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_no_d  = bit_no_q;
    div_cnt_d = div_cnt_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    tx_ready  = 1'b0;
    load      = 1'b0;
    go_hold   = 1'b0;
    phase_end = (div_cnt_q == DivMax);

    if (state_q != StIdle) begin
      div_cnt_d = phase_end ? '0 : div_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_ready  = 1'b1;
        div_cnt_d = '0;
        load      = bus.tx_valid;
      end
      StSetup: begin
        if (phase_end) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          state_d = StLow;
          sclk_d  = 1'b0;
        end
      end
      StLow: begin
        if (phase_end) begin
          if (bit_no_q != 3'd7) begin
            sr_d     = {1'b0, sr_q[7:1]};
            bit_no_d = bit_no_q + 3'd1;
            mosi_d   = sr_q[1];
            state_d  = StHigh;
            sclk_d   = 1'b1;
          end else if (!last_q) begin
            // Final LOW cycle of an open frame: a waiting byte chains with cs held low.
            tx_ready = 1'b1;
            load     = bus.tx_valid;
            go_hold  = !bus.tx_valid;
          end else begin
            go_hold = 1'b1;
          end
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (go_hold) begin
      state_d = StHold;
      cs_d    = 1'b1;
      mosi_d  = 1'b0;
    end

    if (load) begin
      sr_d      = bus.tx_data;
      last_d    = bus.tx_last;
      bit_no_d  = '0;
      div_cnt_d = '0;
      state_d   = StSetup;
      cs_d      = 1'b0;
      sclk_d    = 1'b0;
      mosi_d    = bus.tx_data[0];
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.busy     = (state_q != StIdle);
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_mosi = mosi_q;

  // With cs deasserted the link must sit at its idle levels.
  cs_idle_levels: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    cs_q |-> (!sclk_q && !mosi_q));

endmodule

// File: doc/spi_byte_tx.md
# spi_byte_tx

SPI master transmitter that serialises bytes LSB-first onto a three-wire link (sclk, mosi, active-low cs), which the board-side SPI byte receiver FSM consumes. It sits in the sys_clk domain of the host FPGA and is fed by a valid/ready byte stream. It can chain several bytes under one cs assertion or close the frame after any byte.

## Interface
Parameters:
- CLK_DIV, default 4: sys_clk cycles per sclk half-period. Legal range ≥ 2, so the receiver sees each level for ≥ 2 of its own clocks.

Ports:
- sys_clk  input  1  single clock; all logic is on its rising edge
- sys_rst_n  input  1  asynchronous, active-low reset
- tx_data  input  8  byte to send; bit 0 is sent first
- tx_valid  input  1  tx_data is valid
- tx_last  input  1  sampled with tx_data; 1 = release cs after this byte
- tx_ready  output  1  byte is accepted in any cycle where tx_valid && tx_ready
- busy  output  1  high whenever state ≠ IDLE
- spi_sclk  output  1  serial clock; idles low
- spi_mosi  output  1  serial data; 0 when cs is high
- spi_cs  output  1  chip select, active-low; idles high

## Operation
- Shift register sr[7:0], bit counter bit_no[2:0], half-period counter div_cnt of width clog2(CLK_DIV), last_q flag. All are registered.
- spi_sclk, spi_cs and spi_mosi are driven directly from registers, so there is no combinational path to the pins.
- States:
  - IDLE: cs = 1, sclk = 0, mosi = 0. tx_ready = 1 once the hold counter has expired. On accept: sr ← tx_data, last_q ← tx_last, bit_no ← 0, go to SETUP.
  - SETUP: cs = 0, sclk = 0, mosi = sr[0]. Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: sclk = 1, lasts CLK_DIV cycles, then go to LOW. mosi is held stable.
  - LOW: sclk = 0, lasts CLK_DIV cycles. mosi is held for the whole half-period, because the receiver samples after it sees the falling edge. At the end of LOW:
    - bit_no < 7: shift sr right, bit_no + 1, mosi ← new sr[0], go to HIGH.
    - bit_no = 7: go to END.
- END (zero-length decision made in the final LOW cycle):
  - If last_q = 0 and tx_valid is high in that final LOW cycle: tx_ready = 1 for that one cycle. Load the new byte, bit_no ← 0, go to SETUP with cs held low (chained byte).
  - Otherwise: go to HOLD with cs ← 1 and mosi ← 0.
- HOLD: cs = 1 for CLK_DIV cycles, then IDLE. This is the minimum cs-high time, so the receiver returns to its idle state.
- tx_ready is 0 in SETUP, HIGH, HOLD, and in every LOW cycle except the final cycle of bit 7 when last_q = 0.
- tx_last, when asserted on a chained byte, closes the frame after that byte.
- Bits leave in the order sr[0] … sr[7], matching the receiver's {mosi, data[7:1]} shift.

## Timing
- Reset (asynchronous assertion, synchronous effect on the next edge after deassertion): state = IDLE, spi_cs = 1, spi_sclk = 0, spi_mosi = 0, busy = 0, sr = 0, bit_no = 0, div_cnt = 0, last_q = 0.
  - tx_ready = 1 on the first cycle after reset release (hold counter is cleared).
- Reset mid-frame forces the pins to idle immediately. The receiver flags an error; the partial byte is dropped and there is no retry.
- With D = CLK_DIV and accept in cycle 0 (single byte, last = 1):
  - cs low: cycles 1 … 17D.
  - Bit k: rising edge at 1 + D + 2kD, falling edge at 1 + 2D + 2kD, for k = 0 … 7.
  - cs high at 17D + 1; tx_ready again at 18D + 1.
  - For D = 4: cs low 1–68, last falling edge at 65, cs high at 69, ready at 73.
- Chained byte: the accept cycle is the final LOW cycle of bit 7 (cycle 17D for the first byte). The next byte's SETUP starts the following cycle; each extra byte adds 16D + D cycles of cs low.
- Simultaneous tx_valid and reset: reset wins and the byte is not accepted.
- tx_valid held high through HIGH or LOW phases has no effect.
- div_cnt counts 0 … D−1 and wraps on every phase change.
- bit_no wraps 7 → 0 only on a chained load.

## Test plan
- Reset released, D = 4, send 0xA5 with last = 1 in cycle 0 -> mosi on the 8 falling edges reads 1,0,1,0,0,1,0,1; cs low cycles 1–68; tx_ready back at 73; the receiver model captures 0xA5.
- Two bytes 0x3C (last = 0) then 0xC3 (last = 1), second tx_valid held high -> accepted in cycle 68; cs stays low through both bytes; the receiver model acks 0x3C then 0xC3; exactly 16 rising edges.
- Byte 0x01 with last = 0 and no tx_valid in cycle 68 -> cs high at 69; a new byte offered in cycles 69–72 is not accepted until cycle 73.
- Reset asserted at cycle 30 of a 0xFF frame -> cs = 1, sclk = 0, mosi = 0 within the same cycle; busy = 0; tx_ready = 1 after release; the next byte 0x55 is sent cleanly.
- D = 2, byte 0x80 -> each sclk half-period is exactly 2 cycles; mosi = 0 for 7 bits and 1 on bit 7; cs low cycles 1–34.
- tx_valid toggled randomly during HIGH and LOW phases -> no extra accepts; mosi stable throughout each HIGH and LOW half-period.
